hilo_mdu: RTL and testbench

Multiply/divide unit with architectural HI/LO registers for the MIPS pipeline CPU. It sits in the execute stage beside the combinational ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiplies and moves complete in one cycle. Divides run as a 32-iteration radix-2 restoring divider and hold the pipeline through a stall output. HI/LO are readable every cycle for MFHI/MFLO forwarding.

---
 rtl/hilo_mdu_if.sv | 37 +++
 rtl/hilo_mdu.sv | 137 +++++++++++++
 tb/tb_hilo_mdu.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/hilo_mdu_if.sv
// Execute-stage port bundle for the HI/LO multiply/divide unit, plus the
// shared ALU control codes it decodes (defined here only if the core has not).
`ifndef MULT_CONTROL
`define MULT_CONTROL  5'd11
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 5'd12
`endif
`ifndef DIV_CONTROL
`define DIV_CONTROL   5'd13
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL  5'd14
`endif
`ifndef MTHI_CONTROL
`define MTHI_CONTROL  5'd15
`endif
`ifndef MTLO_CONTROL
`define MTLO_CONTROL  5'd16
`endif

interface hilo_mdu_if;
    logic        start_i;
    logic [4:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;

    modport master (output start_i, op_i, a_i, b_i, flush_i,
                    input  stall_o, hi_o, lo_o, busy_o);
    modport slave  (input  start_i, op_i, a_i, b_i, flush_i,
                    output stall_o, hi_o, lo_o, busy_o);
endinterface

// File: rtl/hilo_mdu.sv
// MIPS HI/LO multiply/divide unit: single-cycle MULT/MULTU/MTHI/MTLO and a
// 32-iteration radix-2 restoring divider that stalls the pipeline.
module hilo_mdu (
    input  logic      clk,
    input  logic      rst_n,
    hilo_mdu_if.slave mdu
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [W-1:0]  quot_q, quot_d, dvs_q, dvs_d, rem_q, rem_d, orig_q, orig_d;
    logic          sgnq_q, sgnq_d, sgnr_q, sgnr_d, div0_q, div0_d;

    logic          is_div_c, is_sdiv_c;
    logic [2*W-1:0] prod_s_c, prod_u_c;
    logic [W:0]    trial_c, diff_c;

    assign is_sdiv_c = (mdu.op_i == `DIV_CONTROL);
    assign is_div_c  = is_sdiv_c || (mdu.op_i == `DIVU_CONTROL);

    // Low 2W bits of the sign-extended product equal the signed product.
    assign prod_s_c = {{W{mdu.a_i[W-1]}}, mdu.a_i} * {{W{mdu.b_i[W-1]}}, mdu.b_i};
    assign prod_u_c = {{W{1'b0}}, mdu.a_i} * {{W{1'b0}}, mdu.b_i};

    // One restoring step: borrow out of diff means the trial is below the divisor.
    assign trial_c = {rem_q, quot_q[W-1]};
    assign diff_c  = trial_c - {1'b0, dvs_q};

    assign mdu.stall_o = ((state_q == IDLE) && mdu.start_i && !mdu.flush_i && is_div_c)
                       || (state_q == DIV);
    assign mdu.busy_o  = (state_q != IDLE);
    assign mdu.hi_o    = hi_q;
    assign mdu.lo_o    = lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        quot_d  = quot_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        orig_d  = orig_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        div0_d  = div0_q;

        case (state_q)
            IDLE: begin
                if (mdu.start_i && !mdu.flush_i) begin
                    case (mdu.op_i)
                        `MULT_CONTROL:  {hi_d, lo_d} = prod_s_c;
                        `MULTU_CONTROL: {hi_d, lo_d} = prod_u_c;
                        `MTHI_CONTROL:  hi_d = mdu.a_i;
                        `MTLO_CONTROL:  lo_d = mdu.a_i;
                        `DIV_CONTROL, `DIVU_CONTROL: begin
                            quot_d  = (is_sdiv_c && mdu.a_i[W-1]) ? -mdu.a_i : mdu.a_i;
                            dvs_d   = (is_sdiv_c && mdu.b_i[W-1]) ? -mdu.b_i : mdu.b_i;
                            sgnq_d  = is_sdiv_c && (mdu.a_i[W-1] ^ mdu.b_i[W-1]);
                            sgnr_d  = is_sdiv_c && mdu.a_i[W-1];
                            div0_d  = (mdu.b_i == '0);
                            orig_d  = mdu.a_i;
                            rem_d   = '0;
                            cnt_d   = '0;
                            state_d = DIV;
                        end
                        default: ;
                    endcase
                end
            end
            DIV: begin
                if (mdu.flush_i) begin
                    state_d = IDLE;
                end else begin
                    if (!diff_c[W]) begin
                        rem_d  = diff_c[W-1:0];
                        quot_d = {quot_q[W-2:0], 1'b1};
                    end else begin
                        rem_d  = trial_c[W-1:0];
                        quot_d = {quot_q[W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) state_d = DONE;
                end
            end
            DONE: begin
                // Same divide is still in EX here, so start_i is not re-decoded.
                if (!mdu.flush_i) begin
                    if (div0_q) begin
                        lo_d = '1;
                        hi_d = orig_q;
                    end else begin
                        lo_d = sgnq_q ? -quot_q : quot_q;
                        hi_d = sgnr_q ? -rem_q  : rem_q;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            quot_q  <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            orig_q  <= '0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            quot_q  <= quot_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            orig_q  <= orig_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            div0_q  <= div0_d;
        end
    end
endmodule

// File: tb/tb_hilo_mdu.sv
// Bench for hilo_mdu: arithmetic reference model checked every cycle, plus
// hand-computed HI/LO/stall expectations for the directed vectors.
`ifndef MULT_CONTROL
`define MULT_CONTROL  5'd11
`endif
`ifndef MULTU_CONTROL
`define MULTU_CONTROL 5'd12
`endif
`ifndef DIV_CONTROL
`define DIV_CONTROL   5'd13
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL  5'd14
`endif
`ifndef MTHI_CONTROL
`define MTHI_CONTROL  5'd15
`endif
`ifndef MTLO_CONTROL
`define MTLO_CONTROL  5'd16
`endif

module tb_hilo_mdu;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  op    = 5'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        flush = 1'b0;

    int ncmp = 0;
    int nfail = 0;
    int stall_cnt = 0;
    int s0;

    hilo_mdu_if mif ();
    assign mif.start_i = start;
    assign mif.op_i    = op;
    assign mif.a_i     = a;
    assign mif.b_i     = b;
    assign mif.flush_i = flush;

    hilo_mdu dut (.clk(clk), .rst_n(rst_n), .mdu(mif));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic is_div(input logic [4:0] o);
        return (o == `DIV_CONTROL) || (o == `DIVU_CONTROL);
    endfunction

    // Reference model: architectural HI/LO plus cycles left until the divider is idle again.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_left = 0;
    longint      sa, sb, q, r, pr;
    logic [63:0] pu;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            if (flush) m_left = 0;
            else if (m_left == 1) begin
                m_hi = p_hi; m_lo = p_lo; m_left = 0;
            end else m_left--;
        end else if (start && !flush) begin
            case (op)
                `MULT_CONTROL: begin
                    pr = longint'($signed(a)) * longint'($signed(b));
                    {m_hi, m_lo} = pr;
                end
                `MULTU_CONTROL: begin
                    pu = {32'd0, a} * {32'd0, b};
                    {m_hi, m_lo} = pu;
                end
                `MTHI_CONTROL: m_hi = a;
                `MTLO_CONTROL: m_lo = a;
                `DIV_CONTROL, `DIVU_CONTROL: begin
                    if (b == 32'd0) begin
                        p_lo = 32'hFFFF_FFFF; p_hi = a;
                    end else if (op == `DIV_CONTROL) begin
                        sa = longint'($signed(a)); sb = longint'($signed(b));
                        q = sa / sb; r = sa % sb;
                        p_lo = q[31:0]; p_hi = r[31:0];
                    end else begin
                        p_lo = a / b; p_hi = a % b;
                    end
                    m_left = 33;
                end
                default: ;
            endcase
        end
    end

    logic e_stall;
    always @(negedge clk) begin
        e_stall = (m_left > 1) || (m_left == 0 && start && !flush && is_div(op));
        chk("hi", mif.hi_o, m_hi);
        chk("lo", mif.lo_o, m_lo);
        chk("busy", 32'(mif.busy_o), 32'(m_left > 0));
        chk("stall", 32'(mif.stall_o), 32'(e_stall));
        if (mif.stall_o) stall_cnt++;
    end

    // Presents an op at posedge+2 and holds it across n edges; returns at posedge+2.
    task automatic run(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv, input int n);
        start = 1'b1; op = o; a = av; b = bv;
        repeat (n) @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic expect_hl(input string nm, input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        chk({nm, "_hi"}, mif.hi_o, eh);
        chk({nm, "_lo"}, mif.lo_o, el);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #22;
        chk("rst_hi", mif.hi_o, 32'd0);
        chk("rst_lo", mif.lo_o, 32'd0);
        chk("rst_busy", 32'(mif.busy_o), 32'd0);
        chk("rst_stall", 32'(mif.stall_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        s0 = stall_cnt;
        run(`MULT_CONTROL, 32'hFFFF_FFFE, 32'd3, 1);
        expect_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run(`MULTU_CONTROL, 32'hFFFF_FFFE, 32'd3, 1);
        expect_hl("multu", 32'h0000_0002, 32'hFFFF_FFFA);
        chk("mul_stall_cycles", 32'(stall_cnt - s0), 32'd0);

        s0 = stall_cnt;
        run(`DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, 34);
        chk("div_stall_cycles", 32'(stall_cnt - s0), 32'd33);
        expect_hl("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run(`DIVU_CONTROL, 32'd100, 32'd7, 34);
        expect_hl("divu_100_7", 32'd2, 32'd14);

        run(`DIVU_CONTROL, 32'h1234_5678, 32'd0, 34);
        expect_hl("divu_by0", 32'h1234_5678, 32'hFFFF_FFFF);

        run(`DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, 34);
        expect_hl("div_ovf", 32'd0, 32'h8000_0000);

        run(`MTHI_CONTROL, 32'hDEAD_BEEF, 32'd0, 1);
        run(`MTLO_CONTROL, 32'h0BAD_F00D, 32'd0, 1);
        expect_hl("mthi_mtlo", 32'hDEAD_BEEF, 32'h0BAD_F00D);

        // Divide annulled in its tenth iteration cycle.
        start = 1'b1; op = `DIV_CONTROL; a = 32'd1000; b = 32'd3;
        repeat (10) @(posedge clk);
        #2; flush = 1'b1;
        @(posedge clk);
        #2; flush = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(mif.busy_o), 32'd0);
        chk("flush_stall", 32'(mif.stall_o), 32'd0);
        @(posedge clk); #2;
        expect_hl("flush_keep", 32'hDEAD_BEEF, 32'h0BAD_F00D);

        start = 1'b1; flush = 1'b1; op = `MULT_CONTROL; a = 32'd5; b = 32'd7;
        @(posedge clk);
        #2; start = 1'b0; flush = 1'b0;
        expect_hl("mult_flushed", 32'hDEAD_BEEF, 32'h0BAD_F00D);

        // Asynchronous reset between edges while dividing.
        start = 1'b1; op = `DIVU_CONTROL; a = 32'd1000; b = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0; start = 1'b0;
        #1;
        chk("arst_hi", mif.hi_o, 32'd0);
        chk("arst_lo", mif.lo_o, 32'd0);
        chk("arst_busy", 32'(mif.busy_o), 32'd0);
        chk("arst_stall", 32'(mif.stall_o), 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        run(`DIVU_CONTROL, 32'd9, 32'd3, 34);
        run(`MULT_CONTROL, 32'd3, 32'd4, 1);
        expect_hl("b2b_mult", 32'd0, 32'd12);
        run(`DIVU_CONTROL, 32'd9, 32'd3, 34);
        expect_hl("divu_9_3", 32'd0, 32'd3);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
